control_fsm: RTL and testbench
==============================

// Module: control_fsm
// PURPOSE
//  Multicycle control unit: the producer side of the ALU control interface.
//  Sequences each instruction through the processor states and drives estado.
//  Decodes the RV32I subset into ALU controls: alusrc, alucontrol, immediate, negativo, branch.
//  Also drives the datapath enables: IR/PC write, memory and register-file strobes.
// PARAMETERS
//  MEM_WAIT  1  cycles spent in MEM_RD / MEM_WR (legal 1..15)
// PORTS
//  clk          in   1   clock; all state changes on posedge
//  reset        in   1   synchronous, active-high reset
//  instruction  in   32  instruction word; valid in FETCH, latched on exit
//  pcsrc        in   1   branch-taken flag from ALU; sampled only in BR
//  estado       out  4   current state code, consumed by ALU and datapath
//  alusrc       out  1   1 = ALU second operand is immediate
//  alucontrol   out  4   ALU operation code
//  immediate    out  12  immediate magnitude (unsigned)
//  negativo     out  1   immediate sign: 1 = subtract magnitude
//  branch       out  1   instruction is beq/bne
//  irwrite      out  1   latch instruction register
//  pcwrite      out  1   PC <= PC+4
//  pcbranch     out  1   PC <= branch target
//  memread      out  1   data memory read strobe
//  memwrite     out  1   data memory write strobe
//  regwrite     out  1   register file write enable
//  memtoreg     out  1   1 = writeback data from memory
//  ill_instr    out  1   one-cycle pulse: unsupported encoding
// BEHAVIOUR
//  States (estado):
//   IDLE    = 1111
//   FETCH   = 0000
//   DECODE  = 0001
//   EXEC    = 0101
//   ADDR    = 0110
//   MEM_RD  = 0111
//   MEM_WR  = 1000
//   WB_ALU  = 1001
//   WB_MEM  = 1010
//   BR      = 1011
//  Reset: estado = IDLE; every other output = 0.
//   Reset wins over all transitions, including mid-MEM_WR; memwrite is 0 from the next edge.
//  Transitions:
//   IDLE -> FETCH unconditionally.
//   FETCH -> DECODE.
//   DECODE -> EXEC for R-type, addi, beq, bne.
//   DECODE -> ADDR for lw, sw.
//   DECODE -> FETCH on illegal encoding.
//   EXEC -> WB_ALU (R-type, addi) or BR (beq, bne).
//   ADDR -> MEM_RD (lw) or MEM_WR (sw).
//   MEM_RD -> WB_MEM, and MEM_WR -> FETCH, each after MEM_WAIT cycles (down-counter, reloaded on entry).
//   WB_ALU, WB_MEM, BR -> FETCH.
//  Latency in cycles: R-type / addi 4; beq / bne 4; sw 3+MEM_WAIT; lw 4+MEM_WAIT.
//  Moore strobes (decoded from estado):
//   irwrite, pcwrite: FETCH only.
//   memread: MEM_RD. memwrite: MEM_WR.
//   regwrite: WB_ALU and WB_MEM. memtoreg: WB_MEM.
//   pcbranch: BR and pcsrc.
//   ill_instr: registered, high for the one cycle after the illegal DECODE.
//  Decoded fields: registered on DECODE exit, held constant until the next DECODE exit.
//   Cleared to 0 on an illegal encoding.
//  Opcode 0110011 (alusrc=0):
//   f7=0000000, f3=000 add -> 0010
//   f7=0100000, f3=000 sub -> 0110
//   f3=111 and -> 0000
//   f3=110 or  -> 0001
//   f3=100 xor -> 0100
//   f3=101 srl -> 0101
//   and/or/xor/srl require f7=0000000.
//  Opcode 0010011 f3=000: addi -> 0011, alusrc=1.
//  Opcode 0000011 f3=010 (lw) and 0100011 f3=010 (sw) -> 0010, alusrc=1.
//  Opcode 1100011: f3=000 beq -> 0110; f3=001 bne -> 1111; alusrc=1, branch=1.
//  Any other opcode/funct combination is illegal.
//  Immediate field (raw 12-bit two's complement):
//   I-type: inst[31:20].
//   S-type: {inst[31:25], inst[11:7]}.
//   B-type: {inst[31], inst[7], inst[30:25], inst[11:8]}, halfword units.
//   R-type: immediate=0, negativo=0.
//  Sign-magnitude output: negativo = raw[11]; immediate = negativo ? (~raw + 1) : raw.
//   raw 0x800 -> immediate 0x800 (unsigned 2048), negativo 1.
// TESTING
//  add 0x002081B3 -> estado 1111,0000,0001,0101,1001,0000; alucontrol 0010; alusrc 0; regwrite only in 1001.
//  addi -5 0xFFB00093 -> immediate 0x005, negativo 1, alucontrol 0011, alusrc 1.
//  lw 0x00812283, MEM_WAIT=3 -> 0000,0001,0110,0111x3,1010; memread 3 cycles; memtoreg+regwrite in 1010; immediate 0x008.
//  beq -8 0xFE208CE3 -> immediate 0x004, negativo 1, branch 1; pcbranch 1 in 1011 iff pcsrc=1 (test both).
//  addi -2048 0x80000093 -> immediate 0x800, negativo 1.
//  0x00000000 -> ill_instr one pulse, back to 0000, fields 0; reset in 1000 -> estado 1111, memwrite 0 next cycle.

Source files
------------

// File: rtl/control_fsm.sv
// Multicycle control unit for the RV32I subset: sequences each instruction through
// the processor states, decodes ALU controls and drives the datapath strobes.
module control_fsm #(
    parameter int MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        pcsrc,
    output logic [3:0]  estado,
    output logic        alusrc,
    output logic [3:0]  alucontrol,
    output logic [11:0] immediate,
    output logic        negativo,
    output logic        branch,
    output logic        irwrite,
    output logic        pcwrite,
    output logic        pcbranch,
    output logic        memread,
    output logic        memwrite,
    output logic        regwrite,
    output logic        memtoreg,
    output logic        ill_instr
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'b1111,
        S_FETCH  = 4'b0000,
        S_DECODE = 4'b0001,
        S_EXEC   = 4'b0101,
        S_ADDR   = 4'b0110,
        S_MEM_RD = 4'b0111,
        S_MEM_WR = 4'b1000,
        S_WB_ALU = 4'b1001,
        S_WB_MEM = 4'b1010,
        S_BR     = 4'b1011
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t      state_reg, state_next;
    logic [31:0] ir_reg;
    logic [3:0]  wait_cnt_reg;

    logic        alusrc_reg, negativo_reg, branch_reg;
    logic [3:0]  alucontrol_reg;
    logic [11:0] immediate_reg;
    logic        irwrite_reg, pcwrite_reg, memread_reg, memwrite_reg;
    logic        regwrite_reg, memtoreg_reg, ill_instr_reg;

    // Decoder outputs, derived from the latched instruction register
    logic        dec_legal, dec_alusrc, dec_branch, dec_mem, dec_load, dec_neg;
    logic [3:0]  dec_aluctl;
    logic [11:0] dec_raw, dec_mag;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        unused_rs1;

    assign opcode     = ir_reg[6:0];
    assign funct3     = ir_reg[14:12];
    assign funct7     = ir_reg[31:25];
    assign unused_rs1 = ^ir_reg[19:15];

    always_comb begin
        dec_legal  = 1'b0;
        dec_alusrc = 1'b0;
        dec_branch = 1'b0;
        dec_mem    = 1'b0;
        dec_load   = 1'b0;
        dec_aluctl = 4'b0000;
        dec_raw    = 12'd0;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_ZERO) begin
                            dec_legal  = 1'b1;
                            dec_aluctl = 4'b0010;
                        end else if (funct7 == F7_ALT) begin
                            dec_legal  = 1'b1;
                            dec_aluctl = 4'b0110;
                        end
                    end
                    3'b111: begin dec_legal = (funct7 == F7_ZERO); dec_aluctl = 4'b0000; end
                    3'b110: begin dec_legal = (funct7 == F7_ZERO); dec_aluctl = 4'b0001; end
                    3'b100: begin dec_legal = (funct7 == F7_ZERO); dec_aluctl = 4'b0100; end
                    3'b101: begin dec_legal = (funct7 == F7_ZERO); dec_aluctl = 4'b0101; end
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                if (funct3 == 3'b000) begin
                    dec_legal  = 1'b1;
                    dec_alusrc = 1'b1;
                    dec_aluctl = 4'b0011;
                    dec_raw    = ir_reg[31:20];
                end
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    dec_legal  = 1'b1;
                    dec_alusrc = 1'b1;
                    dec_mem    = 1'b1;
                    dec_load   = 1'b1;
                    dec_aluctl = 4'b0010;
                    dec_raw    = ir_reg[31:20];
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    dec_legal  = 1'b1;
                    dec_alusrc = 1'b1;
                    dec_mem    = 1'b1;
                    dec_aluctl = 4'b0010;
                    dec_raw    = {ir_reg[31:25], ir_reg[11:7]};
                end
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    dec_legal  = 1'b1;
                    dec_alusrc = 1'b1;
                    dec_branch = 1'b1;
                    dec_aluctl = (funct3 == 3'b000) ? 4'b0110 : 4'b1111;
                    // Branch offset stays in halfword units
                    dec_raw    = {ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8]};
                end
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Sign-magnitude split; -2048 has no positive twin and stays 0x800
    assign dec_neg = dec_raw[11];
    assign dec_mag = dec_neg ? (~dec_raw + 12'd1) : dec_raw;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (!dec_legal)
                    state_next = S_FETCH;
                else if (dec_mem)
                    state_next = S_ADDR;
                else
                    state_next = S_EXEC;
            end
            S_EXEC:   state_next = dec_branch ? S_BR : S_WB_ALU;
            S_ADDR:   state_next = dec_load ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: state_next = (wait_cnt_reg == 4'd0) ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR: state_next = (wait_cnt_reg == 4'd0) ? S_FETCH : S_MEM_WR;
            S_WB_ALU: state_next = S_FETCH;
            S_WB_MEM: state_next = S_FETCH;
            S_BR:     state_next = S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with estado
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            ir_reg         <= 32'd0;
            wait_cnt_reg   <= 4'd0;
            alusrc_reg     <= 1'b0;
            alucontrol_reg <= 4'd0;
            immediate_reg  <= 12'd0;
            negativo_reg   <= 1'b0;
            branch_reg     <= 1'b0;
            irwrite_reg    <= 1'b0;
            pcwrite_reg    <= 1'b0;
            memread_reg    <= 1'b0;
            memwrite_reg   <= 1'b0;
            regwrite_reg   <= 1'b0;
            memtoreg_reg   <= 1'b0;
            ill_instr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_FETCH)
                ir_reg <= instruction;

            if ((state_next == S_MEM_RD || state_next == S_MEM_WR) && state_next != state_reg)
                wait_cnt_reg <= WAIT_LOAD;
            else if (wait_cnt_reg != 4'd0)
                wait_cnt_reg <= wait_cnt_reg - 4'd1;

            irwrite_reg   <= (state_next == S_FETCH);
            pcwrite_reg   <= (state_next == S_FETCH);
            memread_reg   <= (state_next == S_MEM_RD);
            memwrite_reg  <= (state_next == S_MEM_WR);
            regwrite_reg  <= (state_next == S_WB_ALU) || (state_next == S_WB_MEM);
            memtoreg_reg  <= (state_next == S_WB_MEM);
            ill_instr_reg <= (state_reg == S_DECODE) && !dec_legal;

            if (state_reg == S_DECODE) begin
                alusrc_reg     <= dec_legal & dec_alusrc;
                alucontrol_reg <= dec_legal ? dec_aluctl : 4'd0;
                immediate_reg  <= dec_legal ? dec_mag : 12'd0;
                negativo_reg   <= dec_legal & dec_neg;
                branch_reg     <= dec_legal & dec_branch;
            end
        end
    end

    assign estado     = state_reg;
    assign alusrc     = alusrc_reg;
    assign alucontrol = alucontrol_reg;
    assign immediate  = immediate_reg;
    assign negativo   = negativo_reg;
    assign branch     = branch_reg;
    assign irwrite    = irwrite_reg;
    assign pcwrite    = pcwrite_reg;
    assign memread    = memread_reg;
    assign memwrite   = memwrite_reg;
    assign regwrite   = regwrite_reg;
    assign memtoreg   = memtoreg_reg;
    assign ill_instr  = ill_instr_reg;
    // pcsrc is only valid while in BR, so the taken strobe is gated live
    assign pcbranch   = (state_reg == S_BR) && pcsrc;

endmodule

// File: tb/tb_control_fsm.sv
// Table-driven check of control_fsm: per-cycle state/strobe trace and decoded fields
// for each instruction, plus reset and mid-MEM_WR reset sequences.
module tb_control_fsm;

    localparam int MW = 3;

    localparam logic [3:0] IDLE = 4'b1111, FETCH = 4'b0000, DECODE = 4'b0001,
                           EXEC = 4'b0101, ADDR = 4'b0110, MEM_RD = 4'b0111,
                           MEM_WR = 4'b1000, WB_ALU = 4'b1001, WB_MEM = 4'b1010,
                           BR = 4'b1011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = 32'd0;
    logic        pcsrc = 1'b0;
    logic [3:0]  estado, alucontrol;
    logic [11:0] immediate;
    logic        alusrc, negativo, branch, irwrite, pcwrite, pcbranch;
    logic        memread, memwrite, regwrite, memtoreg, ill_instr;

    int checks = 0;
    int failures = 0;
    logic last_ill = 1'b0;

    control_fsm #(.MEM_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .pcsrc(pcsrc),
        .estado(estado), .alusrc(alusrc), .alucontrol(alucontrol),
        .immediate(immediate), .negativo(negativo), .branch(branch),
        .irwrite(irwrite), .pcwrite(pcwrite), .pcbranch(pcbranch),
        .memread(memread), .memwrite(memwrite), .regwrite(regwrite),
        .memtoreg(memtoreg), .ill_instr(ill_instr)
    );

    always #5 clk = ~clk;

    typedef enum int {C_ALU, C_BR, C_LW, C_SW, C_ILL} cls_t;

    typedef struct {
        logic [31:0] instr;
        logic        pc;
        cls_t        cls;
        logic [3:0]  aluctl;
        logic        src;
        logic [11:0] imm;
        logic        neg;
        logic        br;
        string       name;
    } vec_t;

    vec_t vecs[18];

    // {irwrite, pcwrite, memread, memwrite, regwrite, memtoreg, pcbranch, ill_instr}
    function automatic logic [7:0] exp_strobes(logic [3:0] s, logic pc, logic ill);
        return {s == FETCH, s == FETCH, s == MEM_RD, s == MEM_WR,
                (s == WB_ALU) || (s == WB_MEM), s == WB_MEM, (s == BR) && pc, ill};
    endfunction

    function automatic logic [7:0] act_strobes();
        return {irwrite, pcwrite, memread, memwrite, regwrite, memtoreg, pcbranch, ill_instr};
    endfunction

    task automatic check_cycle(input logic [3:0] s, input logic pc, input logic ill,
                               input string name, input int cyc);
        logic [7:0] e;
        e = exp_strobes(s, pc, ill);
        checks++;
        if (estado !== s) begin
            failures++;
            $display("FAIL %s estado cyc%0d: got %b want %b", name, cyc, estado, s);
        end
        checks++;
        if (act_strobes() !== e) begin
            failures++;
            $display("FAIL %s strobes cyc%0d: got %b want %b", name, cyc, act_strobes(), e);
        end
    endtask

    task automatic check_fields(input logic src, input logic [3:0] ctl, input logic [11:0] imm,
                                input logic neg, input logic br, input string name);
        logic [18:0] e, a;
        e = {src, ctl, imm, neg, br};
        a = {alusrc, alucontrol, immediate, negativo, branch};
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s fields {alusrc,aluctl,imm,neg,br}: got %b_%b_%h_%b_%b want %b_%b_%h_%b_%b",
                     name, a[18], a[17:14], a[13:2], a[1], a[0], e[18], e[17:14], e[13:2], e[1], e[0]);
        end
    endtask

    function automatic void build_seq(input cls_t c, output logic [3:0] seq[$]);
        seq = {};
        seq.push_back(DECODE);
        case (c)
            C_ALU: begin seq.push_back(EXEC); seq.push_back(WB_ALU); end
            C_BR:  begin seq.push_back(EXEC); seq.push_back(BR); end
            C_LW: begin
                seq.push_back(ADDR);
                for (int i = 0; i < MW; i++) seq.push_back(MEM_RD);
                seq.push_back(WB_MEM);
            end
            C_SW: begin
                seq.push_back(ADDR);
                for (int i = 0; i < MW; i++) seq.push_back(MEM_WR);
            end
            default: ;
        endcase
        seq.push_back(FETCH);
    endfunction

    // Precondition: called at a negedge with the DUT in FETCH
    task automatic run_vec(input vec_t v);
        logic [3:0] seq[$];
        instruction = v.instr;
        pcsrc = v.pc;
        check_cycle(FETCH, v.pc, last_ill, v.name, 0);
        build_seq(v.cls, seq);
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            check_cycle(seq[i], v.pc, (v.cls == C_ILL) && (i == seq.size() - 1), v.name, i + 1);
        end
        check_fields(v.src, v.aluctl, v.imm, v.neg, v.br, v.name);
        last_ill = (v.cls == C_ILL);
        $display("txn %-10s instr=%h cycles=%0d aluctl=%b imm=%h neg=%b checks=%0d failures=%0d",
                 v.name, v.instr, seq.size(), alucontrol, immediate, negativo, checks, failures);
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if (estado !== IDLE || act_strobes() !== 8'd0 ||
            {alusrc, alucontrol, immediate, negativo, branch} !== 19'd0) begin
            failures++;
            $display("FAIL %s: estado=%b strobes=%b fields=%h want estado=1111 all zero",
                     name, estado, act_strobes(), {alusrc, alucontrol, immediate, negativo, branch});
        end
    endtask

    initial begin
        vecs[0]  = '{32'h002081B3, 1'b0, C_ALU, 4'b0010, 1'b0, 12'h000, 1'b0, 1'b0, "add"};
        vecs[1]  = '{32'hFFB00093, 1'b0, C_ALU, 4'b0011, 1'b1, 12'h005, 1'b1, 1'b0, "addi-5"};
        vecs[2]  = '{32'h00812283, 1'b0, C_LW,  4'b0010, 1'b1, 12'h008, 1'b0, 1'b0, "lw"};
        vecs[3]  = '{32'hFE208CE3, 1'b1, C_BR,  4'b0110, 1'b1, 12'h004, 1'b1, 1'b1, "beq-tk"};
        vecs[4]  = '{32'hFE208CE3, 1'b0, C_BR,  4'b0110, 1'b1, 12'h004, 1'b1, 1'b1, "beq-nt"};
        vecs[5]  = '{32'h80000093, 1'b0, C_ALU, 4'b0011, 1'b1, 12'h800, 1'b1, 1'b0, "addi-2048"};
        vecs[6]  = '{32'h00000000, 1'b0, C_ILL, 4'b0000, 1'b0, 12'h000, 1'b0, 1'b0, "ill-zero"};
        vecs[7]  = '{32'h40208133, 1'b0, C_ALU, 4'b0110, 1'b0, 12'h000, 1'b0, 1'b0, "sub"};
        vecs[8]  = '{32'h0020F1B3, 1'b0, C_ALU, 4'b0000, 1'b0, 12'h000, 1'b0, 1'b0, "and"};
        vecs[9]  = '{32'h0020E1B3, 1'b0, C_ALU, 4'b0001, 1'b0, 12'h000, 1'b0, 1'b0, "or"};
        vecs[10] = '{32'h0020C1B3, 1'b0, C_ALU, 4'b0100, 1'b0, 12'h000, 1'b0, 1'b0, "xor"};
        vecs[11] = '{32'h0020D1B3, 1'b0, C_ALU, 4'b0101, 1'b0, 12'h000, 1'b0, 1'b0, "srl"};
        vecs[12] = '{32'hFE20AE23, 1'b0, C_SW,  4'b0010, 1'b1, 12'h004, 1'b1, 1'b0, "sw-4"};
        vecs[13] = '{32'hFE209CE3, 1'b1, C_BR,  4'b1111, 1'b1, 12'h004, 1'b1, 1'b1, "bne-tk"};
        vecs[14] = '{32'h4020D1B3, 1'b0, C_ILL, 4'b0000, 1'b0, 12'h000, 1'b0, 1'b0, "ill-sra"};
        vecs[15] = '{32'h7FF00093, 1'b0, C_ALU, 4'b0011, 1'b1, 12'h7FF, 1'b0, 1'b0, "addi+2047"};
        vecs[16] = '{32'h4020F1B3, 1'b0, C_ILL, 4'b0000, 1'b0, 12'h000, 1'b0, 1'b0, "ill-andf7"};
        vecs[17] = '{32'h00810283, 1'b0, C_ILL, 4'b0000, 1'b0, 12'h000, 1'b0, 1'b0, "ill-lwf3"};

        // Reset state, with pcsrc high to show pcbranch stays low outside BR
        reset = 1'b1;
        pcsrc = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        $display("txn reset      estado=%b", estado);
        reset = 1'b0;
        pcsrc = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 18; i++)
            run_vec(vecs[i]);

        // Reset while in MEM_WR must drop memwrite at the next edge
        instruction = 32'hFE20AE23;
        pcsrc = 1'b0;
        check_cycle(FETCH, 1'b0, last_ill, "sw-rst", 0);
        @(negedge clk); check_cycle(DECODE, 1'b0, 1'b0, "sw-rst", 1);
        @(negedge clk); check_cycle(ADDR,   1'b0, 1'b0, "sw-rst", 2);
        @(negedge clk); check_cycle(MEM_WR, 1'b0, 1'b0, "sw-rst", 3);
        @(negedge clk); check_cycle(MEM_WR, 1'b0, 1'b0, "sw-rst", 4);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("rst-in-memwr");
        $display("txn sw-rst     estado=%b memwrite=%b", estado, memwrite);
        reset = 1'b0;
        last_ill = 1'b0;
        @(negedge clk);
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
